mod_q_nibble_rom: RTL and testbench

- Constant-table stage of the Kyber (q = 3329) modular multiplier pipeline.
- Takes a 24-bit raw product and maps each of its top three nibbles to that nibble's weight modulo q. The three lookups are named H, M and L.
- Outputs the three 12-bit residues and their 14-bit partial sum with the low 12 product bits. The sum is available both combinationally and registered.
- Downstream logic finishes the reduction: it folds bits [13:12] and does a conditional subtract of q.

---
 rtl/mod_q_pkg.sv | 40 ++++
 rtl/nibble_rom.sv | 39 +++
 rtl/mod_q_nibble_rom.sv | 45 ++++
 tb/tb_mod_q_nibble_rom.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mod_q_pkg.sv
// Purpose : shared constants for the Kyber (q = 3329) nibble-weight reduction tables.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package mod_q_pkg;

    localparam int unsigned Q = 3329;

    // Powers of two reduced mod Q; they are the weights of the l, m and h nibbles.
    localparam logic [11:0] POW12_MOD_Q = 12'd767;
    localparam logic [11:0] POW16_MOD_Q = 12'd2285;
    localparam logic [11:0] POW20_MOD_Q = 12'd3270;

    typedef enum logic [1:0] {
        TBL_H = 2'd0,
        TBL_M = 2'd1,
        TBL_L = 2'd2
    } tbl_sel_e;

    // Packed so a table can be chosen with a plain conditional; entry n is ROM_x[n].
    typedef logic [15:0][11:0] rom_t;

    // (n * 2^20) mod Q
    localparam rom_t ROM_H = {
        12'd2444, 12'd2503, 12'd2562, 12'd2621, 12'd2680, 12'd2739, 12'd2798, 12'd2857,
        12'd2916, 12'd2975, 12'd3034, 12'd3093, 12'd3152, 12'd3211, 12'd3270, 12'd0
    };

    // (n * 2^16) mod Q
    localparam rom_t ROM_M = {
        12'd985,  12'd2029, 12'd3073, 12'd788,  12'd1832, 12'd2876, 12'd591,  12'd1635,
        12'd2679, 12'd394,  12'd1438, 12'd2482, 12'd197,  12'd1241, 12'd2285, 12'd0
    };

    // (n * 2^12) mod Q
    localparam rom_t ROM_L = {
        12'd1518, 12'd751,  12'd3313, 12'd2546, 12'd1779, 12'd1012, 12'd245,  12'd2807,
        12'd2040, 12'd1273, 12'd506,  12'd3068, 12'd2301, 12'd1534, 12'd767,  12'd0
    };

endpackage

// File: rtl/nibble_rom.sv
// Purpose : 16x12 constant lookup of one nibble's weight mod Q; SEL picks the H/M/L table.
// Latency : combinational, zero cycles.
// Backpressure: none. Ports: a[3:0] nibble index in, spo[11:0] residue out.
module nibble_rom
    import mod_q_pkg::*;
#(
    parameter tbl_sel_e SEL = TBL_L
) (
    input  logic [3:0]  a,
    output logic [11:0] spo
);

    localparam rom_t TBL = (SEL == TBL_H) ? ROM_H :
                           (SEL == TBL_M) ? ROM_M : ROM_L;

    always_comb begin
        spo = '0;
        case (a)
            4'd0:    spo = TBL[0];
            4'd1:    spo = TBL[1];
            4'd2:    spo = TBL[2];
            4'd3:    spo = TBL[3];
            4'd4:    spo = TBL[4];
            4'd5:    spo = TBL[5];
            4'd6:    spo = TBL[6];
            4'd7:    spo = TBL[7];
            4'd8:    spo = TBL[8];
            4'd9:    spo = TBL[9];
            4'd10:   spo = TBL[10];
            4'd11:   spo = TBL[11];
            4'd12:   spo = TBL[12];
            4'd13:   spo = TBL[13];
            4'd14:   spo = TBL[14];
            4'd15:   spo = TBL[15];
            default: spo = '0;
        endcase
    end

endmodule

// File: rtl/mod_q_nibble_rom.sv
// Purpose : maps the top three nibbles of a 24-bit product to residues mod Q and adds the low 12 bits.
// Latency : lut_*/sum_c combinational; sum_q one cycle after din.
// Backpressure: none; en=0 loads a zero slot into sum_q (it does not hold).
// Ports: clk, rst_n (async active-low), en, din[23:0] -> lut_h/m/l[11:0], sum_c[13:0], sum_q[13:0].
module mod_q_nibble_rom
    import mod_q_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] din,
    output logic [11:0] lut_h,
    output logic [11:0] lut_m,
    output logic [11:0] lut_l,
    output logic [13:0] sum_c,
    output logic [13:0] sum_q
);

    logic [12:0] sum_hm;
    logic [12:0] sum_llo;

    nibble_rom #(.SEL(TBL_H)) u_rom_h (.a(din[23:20]), .spo(lut_h));
    nibble_rom #(.SEL(TBL_M)) u_rom_m (.a(din[19:16]), .spo(lut_m));
    nibble_rom #(.SEL(TBL_L)) u_rom_l (.a(din[15:12]), .spo(lut_l));

    // Worst case 3270+3073+3313+4095 = 13751 fits in 14 bits, so no wrap is possible.
    always_comb begin
        sum_hm  = {1'b0, lut_h} + {1'b0, lut_m};
        sum_llo = {1'b0, lut_l} + {1'b0, din[11:0]};
        sum_c   = {1'b0, sum_hm} + {1'b0, sum_llo};
    end

    // en selects between the new sum and a zero bubble, so an unknown din
    // never propagates into the register while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_c;
        end else begin
            sum_q <= '0;
        end
    end

endmodule

// File: tb/tb_mod_q_nibble_rom.sv
module tb_mod_q_nibble_rom;

    localparam int QM = 3329;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] din;
    logic [11:0] lut_h, lut_m, lut_l;
    logic [13:0] sum_c, sum_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int  dval;
        bit  chk_comb;
        int  exp_h, exp_m, exp_l, exp_sum;
        int  exp_q;
    } txn_t;

    txn_t sb_q[$];

    mod_q_nibble_rom dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (din),
        .lut_h (lut_h),
        .lut_m (lut_m),
        .lut_l (lut_l),
        .sum_c (sum_c),
        .sum_q (sum_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: weight of nibble n at bit position k, reduced with plain arithmetic.
    function automatic int ref_w(int n, int k);
        return (n * (1 << k)) % QM;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one value at the falling edge and queue what the DUT must show.
    // sum_override >= 0 replaces the model sum with a hand-derived constant.
    task automatic apply(input logic [23:0] d, input logic e, input int sum_override);
        txn_t t;
        @(negedge clk);
        din = d;
        en  = e;
        t.dval     = int'(d);
        t.chk_comb = 1'b1;
        t.exp_h    = ref_w(int'(d[23:20]), 20);
        t.exp_m    = ref_w(int'(d[19:16]), 16);
        t.exp_l    = ref_w(int'(d[15:12]), 12);
        t.exp_sum  = (sum_override >= 0) ? sum_override
                                         : t.exp_h + t.exp_m + t.exp_l + int'(d[11:0]);
        t.exp_q    = e ? t.exp_sum : 0;
        sb_q.push_back(t);
    endtask

    task automatic apply_x();
        txn_t t;
        @(negedge clk);
        din = 'x;
        en  = 1'b0;
        t.dval     = 0;
        t.chk_comb = 1'b0;
        t.exp_h    = 0;
        t.exp_m    = 0;
        t.exp_l    = 0;
        t.exp_sum  = 0;
        t.exp_q    = 0;
        sb_q.push_back(t);
    endtask

    // Monitor: din is stable from the falling edge through the next rising edge,
    // so just after the rising edge both combinational outputs and sum_q belong
    // to the same queued transaction.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            txn_t t;
            t = sb_q.pop_front();
            if (t.chk_comb) begin
                chk("lut_h", int'(lut_h), t.exp_h);
                chk("lut_m", int'(lut_m), t.exp_m);
                chk("lut_l", int'(lut_l), t.exp_l);
                chk("sum_c", int'(sum_c), t.exp_sum);
                chk("sum_c_mod_q", int'(sum_c) % QM, t.dval % QM);
            end
            chk("sum_q", int'(sum_q), t.exp_q);
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        din   = 24'hFFFFFF;
        #1;
        chk("reset_sum_q", int'(sum_q), 0);
        chk("reset_sum_c", int'(sum_c), 9042);
        @(posedge clk);
        #1;
        chk("reset_hold_sum_q", int'(sum_q), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unknown input with en low must leave a clean zero in sum_q.
        apply_x();
        apply_x();

        // Every table entry, one field at a time.
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 16; n++) begin
                logic [23:0] d;
                d = 24'(n) << (12 + 4 * f);
                apply(d, 1'b1, -1);
            end
        end

        // Worked example and enable gating on a held din.
        apply(24'h1A61E8, 1'b1, 7907);
        apply(24'h1A61E8, 1'b0, 7907);
        apply(24'h1A61E8, 1'b1, 7907);
        // Large sum, no wrap.
        apply(24'h1DFFFF, 1'b1, 11956);
        apply(24'hFFFFFF, 1'b1, 9042);

        for (int i = 0; i < 1000; i++) begin
            logic [23:0] d;
            d = 24'($urandom);
            apply(d, ($urandom_range(0, 3) != 0), -1);
        end

        // Drain the scoreboard with a bounded wait.
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);

        // Reset in the middle of operation: register clears at once,
        // combinational path keeps following din.
        @(negedge clk);
        din = 24'h1A61E8;
        en  = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset_sum_q", int'(sum_q), 7907);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_sum_q", int'(sum_q), 0);
        chk("midop_reset_sum_c", int'(sum_c), 7907);
        din = 24'h1DFFFF;
        #1;
        chk("reset_comb_follow", int'(sum_c), 11956);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
